parity_serial_tx: RTL

PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

---
 rtl/parity_serial_tx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/parity_serial_tx.sv
// Serial transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Each bit lasts CLKS_PER_BIT clocks, and all outputs come straight from flops.
module parity_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       even_odd,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c;
  logic             bit_end_c;

  // ready_q is high only in IDLE, so this also implies the FSM is idle.
  assign accept_c  = valid & ready_q;
  assign bit_end_c = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept_c)                          state_d = S_START;
      S_START:  if (bit_end_c)                         state_d = S_DATA;
      S_DATA:   if (bit_end_c && bit_idx_q == 3'd7)    state_d = S_PARITY;
      S_PARITY: if (bit_end_c)                         state_d = S_STOP;
      S_STOP:   if (bit_end_c)                         state_d = S_IDLE;
      default:                                         state_d = S_IDLE;
    endcase
  end

  // Bit-period counter, bit index and the byte latched on accept.
  always_comb begin
    cnt_d     = (state_q == S_IDLE || bit_end_c) ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    if (state_q == S_DATA && bit_end_c) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end
    if (accept_c) begin
      data_d   = data;
      parity_d = even_odd ? ~(^data) : ^data;
    end
  end

  // The outputs are decoded from the next state, so each one is registered
  // and matches the state it describes.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = (state_q == S_STOP) && bit_end_c;
    unique case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_idx_d];
      S_PARITY: tx_d = parity_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
